// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and three-cycle grant/access/response sequencer in front of DMEM.
// Optional request checking is enabled by defining DMEM_ARB_CHECK_EN.
module dmem_arbiter #(
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter int unsigned DMEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [2:0]  r0_mode,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [2:0]  r1_mode,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,

    output logic        dm_cs,
    output logic        dm_w,
    output logic        dm_r,
    output logic [2:0]  dm_mode,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t      state;
    logic        last;
    logic        id_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        grant_any;
    logic        winner;
    logic        win_we;
    logic [2:0]  win_mode;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_err;

    // On a tie the requester not named by last wins, so last=1 favours r0.
    assign grant_any = (state == StIdle) && (r0_req || r1_req);
    assign winner    = r1_req && (!r0_req || !last);
    assign r0_gnt    = grant_any && !winner;
    assign r1_gnt    = grant_any && winner;

    assign win_we    = winner ? r1_we    : r0_we;
    assign win_mode  = winner ? r1_mode  : r0_mode;
    assign win_addr  = winner ? r1_addr  : r0_addr;
    assign win_wdata = winner ? r1_wdata : r0_wdata;

`ifdef DMEM_ARB_CHECK_EN
    localparam logic [31:0] DmemLast = DMEM_BASE + 32'(4 * DMEM_WORDS) - 32'd1;

    always_comb begin
        win_err = 1'b0;
        case (win_mode)
            3'b000:         win_err = (win_addr[1:0] != 2'b00);
            3'b001, 3'b010: win_err = win_addr[0];
            3'b011, 3'b100: win_err = 1'b0;
            default:        win_err = 1'b1;
        endcase
        if (win_we && (win_mode == 3'b010 || win_mode == 3'b100)) begin
            win_err = 1'b1;
        end
        if (win_addr < DMEM_BASE || win_addr > DmemLast) begin
            win_err = 1'b1;
        end
    end
`else
    assign win_err = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{DMEM_BASE, DMEM_WORDS};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            last      <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            dm_cs     <= 1'b0;
            dm_w      <= 1'b0;
            dm_r      <= 1'b0;
            dm_mode   <= '0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_any) begin
                        state    <= StAccess;
                        last     <= winner;
                        id_q     <= winner;
                        we_q     <= win_we;
                        err_q    <= win_err;
                        dm_mode  <= win_mode;
                        dm_addr  <= win_addr;
                        dm_wdata <= win_wdata;
                        // A flagged request walks through ACCESS without touching memory.
                        dm_cs    <= !win_err;
                        dm_w     <= win_we && !win_err;
                        dm_r     <= !win_we && !win_err;
                    end
                end
                StAccess: begin
                    state     <= StResp;
                    dm_cs     <= 1'b0;
                    dm_w      <= 1'b0;
                    dm_r      <= 1'b0;
                    r0_rvalid <= !id_q;
                    r1_rvalid <= id_q;
                    if (!we_q && !err_q) begin
                        rdata_q <= dm_rdata;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    r0_rvalid <= 1'b0;
                    r1_rvalid <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    logic [31:0] resp_data;
    assign resp_data = (we_q || err_q) ? 32'h0 : rdata_q;

    assign r0_rdata = r0_rvalid ? resp_data : 32'h0;
    assign r1_rdata = r1_rvalid ? resp_data : 32'h0;
    assign r0_err   = r0_rvalid && err_q;
    assign r1_err   = r1_rvalid && err_q;

endmodule
